// File: rtl/miss_classifier_pkg.sv
// miss_classifier_pkg: shared types and classification rule for the miss classifier
package miss_classifier_pkg;
  localparam int WAYS_LOG_BITS = 3;
  typedef enum logic [1:0] {
    MISS_NONE  = 2'd0,
    COMPULSORY = 2'd1,
    CAPACITY   = 2'd2,
    CONFLICT   = 2'd3
  } miss_class_t;
  typedef enum logic [1:0] {
    ST_COUNT    = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REQ      = 2'd2,
    ST_COOLDOWN = 2'd3
  } mutate_state_t;
  function automatic miss_class_t classify(input logic miss, input logic fa_hit, input logic fa_full);
    return !miss ? MISS_NONE : fa_hit ? CONFLICT : fa_full ? CAPACITY : COMPULSORY;
  endfunction
endpackage

// File: rtl/miss_classifier_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
//   clk, rst_n : clock, synchronous active-low reset
//   inc, clr   : increment request, clear (clear wins)
//   count      : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk)
    if (!rst_n || clr) r_count <= '0;
    else if (inc && r_count != '1) r_count <= r_count + 1'b1;
  assign count = r_count;
endmodule

// File: rtl/miss_classifier.sv
// miss_classifier: classifies real-cache misses and requests associativity mutations per epoch
//   access_*/full_assoc_*/real_cache_full : resolved access and shadow tag status
//   miss_class, miss_class_valid           : registered classification of the last access
//   *_cnt                                  : current-epoch saturating class counts
//   ways_log, mutate_req/ways_log/ack      : granted associativity and req/ack mutation handshake
//   epoch_done                             : pulse while the epoch is evaluated
module miss_classifier
  import miss_classifier_pkg::*;
#(
  parameter int EPOCH_LEN      = 1024,
  parameter int CNT_W          = 16,
  parameter int CONFLICT_HI    = 64,
  parameter int CONFLICT_LO    = 8,
  parameter int MIN_WAYS_LOG   = 0,
  parameter int MAX_WAYS_LOG   = 3,
  parameter int RESET_WAYS_LOG = 2,
  parameter int COOLDOWN       = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     access_valid,
  input  logic                     access_miss,
  input  logic                     full_assoc_hit,
  input  logic                     full_assoc_full,
  input  logic                     real_cache_full,
  output miss_class_t              miss_class,
  output logic                     miss_class_valid,
  output logic [CNT_W-1:0]         compulsory_cnt,
  output logic [CNT_W-1:0]         capacity_cnt,
  output logic [CNT_W-1:0]         conflict_cnt,
  output logic [WAYS_LOG_BITS-1:0] ways_log,
  output logic                     mutate_req,
  output logic [WAYS_LOG_BITS-1:0] mutate_ways_log,
  input  logic                     mutate_ack,
  output logic                     epoch_done
);
  localparam int ACC_W = $clog2(EPOCH_LEN);
  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam logic [WAYS_LOG_BITS-1:0] RST_WAYS = WAYS_LOG_BITS'(RESET_WAYS_LOG);
  mutate_state_t              r_state, w_next;
  miss_class_t                r_class, w_class;
  logic                       r_valid;
  logic [ACC_W-1:0]           r_acc;
  logic [CD_W-1:0]            r_cool;
  logic [WAYS_LOG_BITS-1:0]   r_ways, r_mwl, w_target;
  logic                       w_count, w_last, w_grow, w_shrink, w_change, w_ack, w_clr, w_cool_done;
  always_comb begin
    w_class     = classify(access_miss, full_assoc_hit, full_assoc_full);
    w_count     = r_state == ST_COUNT && access_valid;
    w_last      = w_count && r_acc == ACC_W'(EPOCH_LEN - 1);
    // thresholds are compared at full int width so narrow counters never truncate them
    w_grow      = 32'(conflict_cnt) >= CONFLICT_HI && 32'(r_ways) < MAX_WAYS_LOG;
    w_shrink    = 32'(conflict_cnt) <= CONFLICT_LO && capacity_cnt > conflict_cnt &&
                  real_cache_full && 32'(r_ways) > MIN_WAYS_LOG;
    w_change    = w_grow || w_shrink;
    w_target    = w_grow ? r_ways + 1'b1 : r_ways - 1'b1;
    w_ack       = r_state == ST_REQ && mutate_ack;
    w_clr       = (r_state == ST_EVAL && !w_change) || w_ack;
    w_cool_done = r_cool == CD_W'(COOLDOWN - 1);
    w_next      = r_state == ST_COUNT ? (w_last ? ST_EVAL : ST_COUNT) :
                  r_state == ST_EVAL  ? (w_change ? ST_REQ : ST_COUNT) :
                  r_state == ST_REQ   ? (mutate_ack ? ST_COOLDOWN : ST_REQ) :
                  (w_cool_done ? ST_COUNT : ST_COOLDOWN);
  end
  always_ff @(posedge clk)
    if (!rst_n) r_state <= ST_COUNT;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_class <= MISS_NONE;
      r_valid <= 1'b0;
      r_acc   <= '0;
      r_cool  <= '0;
      r_ways  <= RST_WAYS;
      r_mwl   <= RST_WAYS;
    end else begin
      r_valid <= access_valid;
      if (access_valid) r_class <= w_class;
      if (w_count) r_acc <= w_last ? '0 : r_acc + 1'b1;
      if (r_state == ST_EVAL && w_change) r_mwl <= w_target;
      if (w_ack) r_ways <= r_mwl;
      r_cool <= r_state == ST_COOLDOWN ? r_cool + 1'b1 : '0;
    end
  sat_counter #(.W(CNT_W)) u_compulsory (
    .clk(clk), .rst_n(rst_n), .inc(w_count && w_class == COMPULSORY), .clr(w_clr), .count(compulsory_cnt)
  );
  sat_counter #(.W(CNT_W)) u_capacity (
    .clk(clk), .rst_n(rst_n), .inc(w_count && w_class == CAPACITY), .clr(w_clr), .count(capacity_cnt)
  );
  sat_counter #(.W(CNT_W)) u_conflict (
    .clk(clk), .rst_n(rst_n), .inc(w_count && w_class == CONFLICT), .clr(w_clr), .count(conflict_cnt)
  );
  assign miss_class       = r_class;
  assign miss_class_valid = r_valid;
  assign ways_log         = r_ways;
  assign mutate_req       = r_state == ST_REQ;
  assign mutate_ways_log  = r_mwl;
  assign epoch_done       = r_state == ST_EVAL;
endmodule
